// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract using a single full-adder slice, LSB first, one bit per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] cnt;
  logic c, ai, bi, s, co;
  always_comb begin
    ai = a_r[cnt];
    bi = b_r[cnt];
    s  = ai ^ bi ^ c;
    co = (ai & bi) | (c & (ai ^ bi));
  end
  // Subtraction is A + ~B + 1: B is inverted at capture and the carry flop seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r      <= a;
          b_r      <= sub ? ~b : b;
          c        <= sub | cin;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          sum <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
          c   <= co;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout      <= co;
            ovf       <= c ^ co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 8, 1 and 3
module tb_serial_adder;
  typedef struct {
    int         k;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] ir, ov, co, of;
  logic [2:0] ordy = '1;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, sub = 1'b0;
  logic [7:0] s8;
  logic [0:0] s1;
  logic [2:0] s3;
  logic [7:0] so [3];
  logic [2:0] ovp = '0;
  logic       hold = 1'b1;
  exp_t       q[$];
  int         checks = 0, fails = 0, cyc = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin), .sub(sub),
    .sum(s8), .cout(co[0]), .ovf(of[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_ready(ir[1]), .a(a[0:0]), .b(b[0:0]), .cin(cin), .sub(sub),
    .sum(s1), .cout(co[1]), .ovf(of[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  serial_adder #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_ready(ir[2]), .a(a[2:0]), .b(b[2:0]), .cin(cin), .sub(sub),
    .sum(s3), .cout(co[2]), .ovf(of[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  always_comb begin
    so[0] = s8;
    so[1] = {7'b0, s1};
    so[2] = {5'b0, s3};
  end

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1;
    if (!hold) ordy = 3'($urandom);
  end

  function automatic int wid(int k);
    return k == 0 ? 8 : (k == 1 ? 1 : 3);
  endfunction

  // Reference: unsigned arithmetic for sum/cout, signed range test for overflow.
  function automatic exp_t model(int k, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
    exp_t e;
    int w = wid(k);
    int h = 1 << (w - 1);
    int m = (1 << w) - 1;
    int ua = int'(av) & m;
    int ub = int'(bv) & m;
    int sa = ua >= h ? ua - 2 * h : ua;
    int sbv = ub >= h ? ub - 2 * h : ub;
    int full = sb ? ua - ub + 2 * h : ua + ub + int'(ci);
    int r = sb ? sa - sbv : sa + sbv + int'(ci);
    e.k    = k;
    e.sum  = 8'(full & m);
    e.cout = (full >> w) != 0;
    e.ovf  = (r < -h) || (r > h - 1);
    e.acc  = 0;
    return e;
  endfunction

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k]) begin
        if (q.size() == 0 || q[0].k != k) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid dut%0d: got out_valid=1, expected 0 (cycle %0d)", k, cyc);
        end else begin
          chk($sformatf("sum dut%0d", k), int'(so[k]), int'(q[0].sum));
          chk($sformatf("cout dut%0d", k), int'(co[k]), int'(q[0].cout));
          chk($sformatf("ovf dut%0d", k), int'(of[k]), int'(q[0].ovf));
          chk($sformatf("in_ready_done dut%0d", k), int'(ir[k]), 0);
          if (!ovp[k]) chk($sformatf("latency dut%0d", k), cyc - q[0].acc, wid(k));
          if (ordy[k]) void'(q.pop_front());
        end
      end
      ovp[k] = ov[k];
    end
  end

  task automatic issue(int k, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
    exp_t e;
    int n = 0;
    while (!ir[k] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ir[k]) begin
      chk($sformatf("in_ready_timeout dut%0d", k), int'(ir[k]), 1);
      return;
    end
    a = av;
    b = bv;
    cin = ci;
    sub = sb;
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    e = model(k, av, bv, ci, sb);
    e.acc = cyc;
    q.push_back(e);
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_size", q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", int'(ir), 7);
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_sum", int'(s8), 0);
    chk("rst_cout_ovf", int'({co[0], of[0]}), 0);
    #10;
    rst_n = 1'b1;
    hold = 1'b0;
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    issue(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    issue(0, 8'h05, 8'h03, 1'b1, 1'b0);
    issue(0, 8'h00, 8'h01, 1'b0, 1'b1);
    issue(0, 8'h80, 8'h01, 1'b0, 1'b1);
    repeat (150) issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    drain();
    for (int k = 1; k < 3; k++) begin
      for (int av = 0; av < (1 << wid(k)); av++)
        for (int bv = 0; bv < (1 << wid(k)); bv++)
          for (int m = 0; m < 4; m++)
            issue(k, 8'(av), 8'(bv), m[0], m[1]);
      drain();
    end
    hold = 1'b1;
    ordy = '0;
    issue(0, 8'h3C, 8'h5A, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !ov[0]; n++) begin
      @(posedge clk);
      #1;
    end
    chk("hold_valid_rise", int'(ov[0]), 1);
    repeat (5) begin
      start[0] = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      sub = 1'($urandom);
      @(posedge clk);
      #1;
      chk("hold_in_ready", int'(ir[0]), 0);
      chk("hold_valid", int'(ov[0]), 1);
      chk("hold_sum", int'(s8), 'h97);
    end
    start[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("after_hold_valid", int'(ov[0]), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("after_hold_idle", int'(ir[0]), 1);
    hold = 1'b0;
    drain();
    issue(0, 8'h55, 8'h66, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", int'(s8), 0);
    chk("abort_cout_ovf", int'({co[0], of[0]}), 0);
    chk("abort_valid", int'(ov[0]), 0);
    chk("abort_in_ready", int'(ir[0]), 1);
    q.delete();
    #3;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_valid", int'(ov[0]), 0);
    issue(0, 8'h10, 8'h20, 1'b0, 1'b0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
